// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache: FSM states,
// replacement-policy selectors and address-split helpers.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_e;

  localparam int POLICY_FIFO = 0;
  localparam int POLICY_LRU  = 1;

  // Byte offset within a 32-bit word; these address bits are ignored.
  localparam int WORD_LSB = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set replacement state for cache_nway: true-LRU ages or a FIFO pointer,
// chosen at elaboration. Invalid ways always take precedence as victims.
module cache_repl
  import cache_pkg::*;
#(
  parameter int SET_ADDR_LEN = 3,
  parameter int WAY_CNT      = 4,
  parameter int POLICY       = POLICY_LRU,
  localparam int WAY_W       = idx_bits(WAY_CNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SET_ADDR_LEN-1:0] set_idx,
  input  logic [WAY_CNT-1:0]      valid,
  input  logic                    touch_valid,
  input  logic [SET_ADDR_LEN-1:0] touch_set,
  input  logic [WAY_W-1:0]        touch_way,
  input  logic                    fill,
  output logic [WAY_W-1:0]        victim_way
);

  localparam int SETS = 1 << SET_ADDR_LEN;

  logic [WAY_W-1:0] policy_way;
  logic [WAY_W-1:0] invalid_way;
  logic             has_invalid;

  always_comb begin
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int unsigned w = 0; w < WAY_CNT; w++) begin
      if (!has_invalid && !valid[w]) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
    victim_way = has_invalid ? invalid_way : policy_way;
  end

  if (POLICY == POLICY_LRU) begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAY_CNT];
    logic [WAY_W-1:0] age_d [SETS][WAY_CNT];
    logic [WAY_W-1:0] touched_age;
    logic             unused_fill;

    assign unused_fill = fill;

    // Ages stay a permutation: only ways younger than the touched one shift.
    always_comb begin
      age_d       = age_q;
      touched_age = age_q[touch_set][touch_way];
      if (touch_valid) begin
        for (int unsigned w = 0; w < WAY_CNT; w++) begin
          if (age_q[touch_set][w] < touched_age)
            age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
        end
        age_d[touch_set][touch_way] = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAY_CNT; w++)
            age_q[s][w] <= WAY_W'(w);
      end else begin
        age_q <= age_d;
      end
    end

    always_comb begin
      policy_way = '0;
      for (int unsigned w = 0; w < WAY_CNT; w++)
        if (age_q[set_idx][w] == WAY_W'(WAY_CNT - 1)) policy_way = WAY_W'(w);
    end
  end else begin : g_fifo
    logic [WAY_W-1:0] ptr_q [SETS];
    logic [WAY_W-1:0] ptr_d [SETS];
    logic             unused_touch;

    assign unused_touch = touch_valid;

    always_comb begin
      ptr_d = ptr_q;
      if (fill && touch_way == ptr_q[touch_set])
        ptr_d[touch_set] = (ptr_q[touch_set] == WAY_W'(WAY_CNT - 1)) ? '0
                                                                     : ptr_q[touch_set] + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end

    assign policy_way = ptr_q[set_idx];
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate data cache with a blocking
// CPU miss handshake, a line-wide memory port and hit/miss counters.
module cache_nway
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6,
  parameter int WAY_CNT       = 4,
  parameter int POLICY        = POLICY_LRU
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            addr,
  input  logic                                   rd_req,
  input  logic                                   wr_req,
  input  logic [31:0]                            wr_data,
  output logic [31:0]                            rd_data,
  output logic                                   miss,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
  output logic                                   mem_rd_req,
  output logic                                   mem_wr_req,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
  input  logic                                   mem_gnt,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt
);

  localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int LINE_W       = 32 * (1 << LINE_ADDR_LEN);
  localparam int WAY_W        = idx_bits(WAY_CNT);
  localparam int SET_LSB      = WORD_LSB + LINE_ADDR_LEN;
  localparam int TAG_LSB      = SET_LSB + SET_ADDR_LEN;

  logic [LINE_W-1:0]       lines_q [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0] tags_q  [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      valid_q [SETS];
  logic [WAY_CNT-1:0]      dirty_q [SETS];

  state_e                  state_q, state_d;
  logic [31:0]             rd_data_q, rd_data_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [LINE_W-1:0]       wr_line_q, wr_line_d, fill_buf_q, fill_buf_d;
  logic [MEM_ADDR_LEN-1:0] wr_addr_q, wr_addr_d, fill_addr_q, fill_addr_d;
  logic [WAY_W-1:0]        fill_way_q, fill_way_d;

  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [SET_ADDR_LEN-1:0]  set_idx, fill_set, touch_set;
  logic [TAG_ADDR_LEN-1:0]  tag_in, fill_tag;
  logic [WAY_W-1:0]         hit_way, victim_way, touch_way;
  logic                     hit, word_we, line_we, touch_valid, fill_en;

  assign word_idx = addr[WORD_LSB +: LINE_ADDR_LEN];
  assign set_idx  = addr[SET_LSB +: SET_ADDR_LEN];
  assign tag_in   = addr[TAG_LSB +: TAG_ADDR_LEN];
  assign fill_set = fill_addr_q[SET_ADDR_LEN-1:0];
  assign fill_tag = fill_addr_q[MEM_ADDR_LEN-1:SET_ADDR_LEN];

  if (TAG_LSB + TAG_ADDR_LEN < 32) begin : g_unused_hi
    logic unused_addr;
    assign unused_addr = ^{addr[31:TAG_LSB+TAG_ADDR_LEN], addr[WORD_LSB-1:0]};
  end else begin : g_unused_lo
    logic unused_addr;
    assign unused_addr = ^addr[WORD_LSB-1:0];
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAY_CNT; w++) begin
      if (!hit && valid_q[set_idx][w] && tags_q[set_idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_repl #(
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .WAY_CNT      (WAY_CNT),
    .POLICY       (POLICY)
  ) u_repl (
    .clk         (clk),
    .rst         (rst),
    .set_idx     (set_idx),
    .valid       (valid_q[set_idx]),
    .touch_valid (touch_valid),
    .touch_set   (touch_set),
    .touch_way   (touch_way),
    .fill        (fill_en),
    .victim_way  (victim_way)
  );

  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    wr_line_d   = wr_line_q;
    fill_buf_d  = fill_buf_q;
    wr_addr_d   = wr_addr_q;
    fill_addr_d = fill_addr_q;
    fill_way_d  = fill_way_q;
    word_we     = 1'b0;
    line_we     = 1'b0;
    touch_valid = 1'b0;
    fill_en     = 1'b0;
    touch_set   = set_idx;
    touch_way   = hit_way;
    unique case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          if (hit) begin
            hit_cnt_d   = hit_cnt_q + 32'd1;
            touch_valid = 1'b1;
            if (rd_req) rd_data_d = lines_q[set_idx][hit_way][{word_idx, 5'd0} +: 32];
            else        word_we   = 1'b1;
          end else begin
            miss_cnt_d  = miss_cnt_q + 32'd1;
            fill_way_d  = victim_way;
            fill_addr_d = {tag_in, set_idx};
            if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
              wr_addr_d = {tags_q[set_idx][victim_way], set_idx};
              wr_line_d = lines_q[set_idx][victim_way];
              state_d   = SWAP_OUT;
            end else begin
              state_d   = SWAP_IN;
            end
          end
        end
      end
      SWAP_OUT: if (mem_gnt) state_d = SWAP_IN;
      SWAP_IN: begin
        if (mem_gnt) begin
          fill_buf_d = mem_rd_line;
          state_d    = SWAP_IN_OK;
        end
      end
      SWAP_IN_OK: begin
        line_we     = 1'b1;
        touch_valid = 1'b1;
        fill_en     = 1'b1;
        touch_set   = fill_set;
        touch_way   = fill_way_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_data_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wr_line_q   <= '0;
      fill_buf_q  <= '0;
      wr_addr_q   <= '0;
      fill_addr_q <= '0;
      fill_way_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wr_line_q   <= wr_line_d;
      fill_buf_q  <= fill_buf_d;
      wr_addr_q   <= wr_addr_d;
      fill_addr_q <= fill_addr_d;
      fill_way_q  <= fill_way_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (word_we) dirty_q[set_idx][hit_way] <= 1'b1;
      if (line_we) begin
        valid_q[fill_set][fill_way_q] <= 1'b1;
        dirty_q[fill_set][fill_way_q] <= 1'b0;
      end
    end
  end

  // Line data and tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (word_we) lines_q[set_idx][hit_way][{word_idx, 5'd0} +: 32] <= wr_data;
    if (line_we) begin
      lines_q[fill_set][fill_way_q] <= fill_buf_q;
      tags_q[fill_set][fill_way_q]  <= fill_tag;
    end
  end

  always_comb begin
    unique case (state_q)
      SWAP_OUT: mem_addr = wr_addr_q;
      SWAP_IN:  mem_addr = fill_addr_q;
      default:  mem_addr = '0;
    endcase
  end

  assign miss        = (rd_req | wr_req) & ~(hit & (state_q == IDLE));
  assign mem_rd_req  = (state_q == SWAP_IN);
  assign mem_wr_req  = (state_q == SWAP_OUT);
  assign mem_wr_line = wr_line_q;
  assign rd_data     = rd_data_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: an LRU and a FIFO instance driven by directed and random
// accesses, checked every cycle against a per-set tag-order model of the cache.
module tb_cache_nway;

  localparam int WAYS = 4;
  localparam int NSET = 8;
  localparam int LW   = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a [2];
  logic [31:0]   addr_a [2], wr_data_a [2], rd_data_a [2], hit_cnt_a [2], miss_cnt_a [2];
  logic          rd_req_a [2], wr_req_a [2], miss_a [2];
  logic [8:0]    mem_addr_a [2];
  logic          mem_rd_req_a [2], mem_wr_req_a [2], mem_gnt_a [2];
  logic [LW-1:0] mem_wr_line_a [2], mem_rd_line_a [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_nway #(
      .LINE_ADDR_LEN (3),
      .SET_ADDR_LEN  (3),
      .TAG_ADDR_LEN  (6),
      .WAY_CNT       (WAYS),
      .POLICY        ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_a[g]),
      .addr        (addr_a[g]),
      .rd_req      (rd_req_a[g]),
      .wr_req      (wr_req_a[g]),
      .wr_data     (wr_data_a[g]),
      .rd_data     (rd_data_a[g]),
      .miss        (miss_a[g]),
      .mem_addr    (mem_addr_a[g]),
      .mem_rd_req  (mem_rd_req_a[g]),
      .mem_wr_req  (mem_wr_req_a[g]),
      .mem_wr_line (mem_wr_line_a[g]),
      .mem_rd_line (mem_rd_line_a[g]),
      .mem_gnt     (mem_gnt_a[g]),
      .hit_cnt     (hit_cnt_a[g]),
      .miss_cnt    (miss_cnt_a[g])
    );
  end

  // Model: backing memory, CPU-visible contents, and per-set resident tags
  // kept oldest-first (FIFO: insertion order, LRU: recency order).
  int unsigned bmem [2][4096];
  int unsigned view [2][4096];
  bit          dirty [2][512];
  int          ord [2][NSET][WAYS];
  int          cnt [2][NSET];

  logic          exp_miss [2], exp_rdq [2], exp_wrq [2];
  logic [8:0]    exp_maddr [2];
  logic [LW-1:0] exp_wline [2];
  logic [31:0]   exp_rdata [2], exp_hit [2], exp_mcnt [2];
  bit            chk_en [2];

  int            vectors = 0;
  int            miscompares = 0;
  int            wb_cnt;
  logic [8:0]    wb_addr;
  logic [LW-1:0] wb_line;

  function automatic void check(string nm, int u, logic [LW-1:0] got, logic [LW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s u%0d: got %h want %h", nm, u, got, want);
    end
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (chk_en[u]) begin
        check("miss", u, miss_a[u], exp_miss[u]);
        check("mem_rd_req", u, mem_rd_req_a[u], exp_rdq[u]);
        check("mem_wr_req", u, mem_wr_req_a[u], exp_wrq[u]);
        check("mem_addr", u, mem_addr_a[u], exp_maddr[u]);
        check("mem_wr_line", u, mem_wr_line_a[u], exp_wline[u]);
        check("rd_data", u, rd_data_a[u], exp_rdata[u]);
        check("hit_cnt", u, hit_cnt_a[u], exp_hit[u]);
        check("miss_cnt", u, miss_cnt_a[u], exp_mcnt[u]);
      end
    end
  end

  function automatic logic [LW-1:0] line_of(int u, int l, bit from_view);
    logic [LW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = from_view ? view[u][l*8+k] : bmem[u][l*8+k];
    return r;
  endfunction

  function automatic int find(int u, int s, int tag);
    for (int i = 0; i < cnt[u][s]; i++) if (ord[u][s][i] == tag) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(int u);
    for (int s = 0; s < NSET; s++) cnt[u][s] = 0;
    for (int l = 0; l < 512; l++) dirty[u][l] = 1'b0;
    for (int i = 0; i < 4096; i++) view[u][i] = bmem[u][i];
    exp_miss[u] = 1'b0; exp_rdq[u] = 1'b0; exp_wrq[u] = 1'b0;
    exp_maddr[u] = '0; exp_wline[u] = '0; exp_rdata[u] = '0;
    exp_hit[u] = '0; exp_mcnt[u] = '0;
  endtask

  task automatic do_reset(int u);
    chk_en[u] = 1'b0;
    rd_req_a[u] = 1'b0; wr_req_a[u] = 1'b0; mem_gnt_a[u] = 1'b0;
    rst_a[u] = 1'b1;
    step();
    step();
    rst_a[u] = 1'b0;
    model_reset(u);
    chk_en[u] = 1'b1;
  endtask

  task automatic access(input int u, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, output bit dut_miss);
    int tag = int'(a[13:8]);
    int s   = int'(a[7:5]);
    int l   = int'(a[13:5]);
    int wi  = int'(a[13:2]);
    int pos, vt, vl, t;
    addr_a[u] = a; rd_req_a[u] = rd; wr_req_a[u] = wr; wr_data_a[u] = wd;
    pos = find(u, s, tag);
    exp_miss[u] = (pos < 0);
    #1;
    dut_miss = miss_a[u];
    if (pos < 0) begin
      mem_gnt_a[u] = 1'($urandom_range(0, 1));
      step();
      mem_gnt_a[u] = 1'b0;
      exp_mcnt[u]++;
      if (cnt[u][s] == WAYS) begin
        vt = ord[u][s][0];
        vl = vt * NSET + s;
        if (dirty[u][vl]) begin
          exp_wrq[u] = 1'b1; exp_maddr[u] = 9'(vl); exp_wline[u] = line_of(u, vl, 1'b1);
          repeat ($urandom_range(0, 3)) step();
          mem_gnt_a[u] = 1'b1;
          wb_cnt++; wb_addr = mem_addr_a[u]; wb_line = mem_wr_line_a[u];
          step();
          mem_gnt_a[u] = 1'b0;
          for (int k = 0; k < 8; k++) bmem[u][vl*8+k] = view[u][vl*8+k];
          dirty[u][vl] = 1'b0;
          exp_wrq[u] = 1'b0;
        end
        for (int i = 0; i < WAYS - 1; i++) ord[u][s][i] = ord[u][s][i+1];
        cnt[u][s]--;
      end
      exp_rdq[u] = 1'b1; exp_maddr[u] = 9'(l);
      repeat ($urandom_range(0, 3)) step();
      mem_rd_line_a[u] = line_of(u, l, 1'b0);
      mem_gnt_a[u] = 1'b1;
      step();
      mem_gnt_a[u] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) mem_rd_line_a[u][k*32 +: 32] = $urandom;
      exp_rdq[u] = 1'b0; exp_maddr[u] = '0;
      step();
      mem_gnt_a[u] = 1'b0;
      ord[u][s][cnt[u][s]] = tag;
      cnt[u][s]++;
      dirty[u][l] = 1'b0;
      pos = cnt[u][s] - 1;
      exp_miss[u] = 1'b0;
    end
    if (u == 0) begin
      t = ord[u][s][pos];
      for (int i = pos; i < cnt[u][s] - 1; i++) ord[u][s][i] = ord[u][s][i+1];
      ord[u][s][cnt[u][s]-1] = t;
    end
    step();
    exp_hit[u]++;
    if (rd) exp_rdata[u] = view[u][wi];
    else begin
      view[u][wi] = wd;
      dirty[u][l] = 1'b1;
    end
    rd_req_a[u] = 1'b0; wr_req_a[u] = 1'b0;
    exp_miss[u] = 1'b0;
  endtask

  initial begin
    bit m;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4096; i++) bmem[u][i] = i;
      rst_a[u] = 1'b1; chk_en[u] = 1'b0;
      addr_a[u] = '0; rd_req_a[u] = 1'b0; wr_req_a[u] = 1'b0; wr_data_a[u] = '0;
      mem_gnt_a[u] = 1'b0; mem_rd_line_a[u] = '0;
    end
    step();
    step();
    for (int u = 0; u < 2; u++) begin
      rst_a[u] = 1'b0;
      model_reset(u);
      chk_en[u] = 1'b1;
    end
    check("reset_hit_cnt", 0, hit_cnt_a[0], 0);
    check("reset_miss_cnt", 0, miss_cnt_a[0], 0);
    check("reset_rd_data", 0, rd_data_a[0], 0);
    check("reset_mem_addr", 0, mem_addr_a[0], 0);

    // Cold read of line 0 then counter and data pins.
    access(0, 32'h0, 1'b1, 1'b0, '0, m);
    check("t1_miss", 0, m, 1);
    check("t1_rd_data", 0, rd_data_a[0], 0);
    check("t1_miss_cnt", 0, miss_cnt_a[0], 1);
    check("t1_hit_cnt", 0, hit_cnt_a[0], 1);

    // Dirty word, evicted by WAYS more tags in set 0, then reread.
    access(0, 32'h4, 1'b0, 1'b1, 32'hDEAD, m);
    wb_cnt = 0;
    for (int t = 1; t <= WAYS; t++) access(0, 32'(t << 8), 1'b1, 1'b0, '0, m);
    check("t2_wb_count", 0, wb_cnt, 1);
    check("t2_wb_addr", 0, wb_addr, 0);
    check("t2_wb_word1", 0, wb_line[63:32], 32'hDEAD);
    access(0, 32'h4, 1'b1, 1'b0, '0, m);
    check("t2_reread", 0, rd_data_a[0], 32'hDEAD);

    // Victim order: tags 1..4 written, tag 1 touched, tag 5 misses.
    do_reset(0);
    for (int u = 0; u < 2; u++) begin
      for (int t = 1; t <= 4; t++) access(u, 32'(t << 8), 1'b0, 1'b1, 32'(t), m);
      access(u, 32'h100, 1'b1, 1'b0, '0, m);
      access(u, 32'h500, 1'b1, 1'b0, '0, m);
      check(u == 0 ? "lru_victim" : "fifo_victim", u, wb_addr, u == 0 ? 16 : 8);
    end
    access(1, 32'h600, 1'b1, 1'b0, '0, m);
    check("fifo_next_victim", 1, wb_addr, 16);

    // Asynchronous reset while the fill is outstanding.
    do_reset(0);
    addr_a[0] = 32'h340; rd_req_a[0] = 1'b1;
    exp_miss[0] = 1'b1;
    step();
    exp_mcnt[0]++; exp_rdq[0] = 1'b1; exp_maddr[0] = 9'd26;
    repeat (3) step();
    chk_en[0] = 1'b0;
    #2;
    rst_a[0] = 1'b1;
    #1;
    check("rst_mem_rd_req", 0, mem_rd_req_a[0], 0);
    check("rst_mem_addr", 0, mem_addr_a[0], 0);
    check("rst_miss_cnt", 0, miss_cnt_a[0], 0);
    do_reset(0);
    access(0, 32'h340, 1'b1, 1'b0, '0, m);
    check("rst_refetch_miss", 0, m, 1);

    // Simultaneous read and write on a hit must read and leave the line clean.
    do_reset(0);
    access(0, 32'h120, 1'b1, 1'b0, '0, m);
    access(0, 32'h120, 1'b1, 1'b1, 32'h12345678, m);
    check("rdwr_rd_data", 0, rd_data_a[0], 72);
    wb_cnt = 0;
    for (int t = 2; t <= 5; t++) access(0, 32'((t << 8) | 32'h20), 1'b1, 1'b0, '0, m);
    check("rdwr_no_wb", 0, wb_cnt, 0);

    for (int i = 0; i < 600; i++) begin
      int op = $urandom_range(0, 2);
      logic [31:0] a = {18'd0, 6'($urandom_range(0, 7)), 3'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7)), 2'd0};
      access(i % 2, a, op != 1, op != 0, $urandom, m);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
